if_fetch: RTL

Instruction-fetch stage of the RISC-V core. It feeds the IF/ID pipeline register with a PC and a 32-bit instruction.
- Owns the architectural fetch PC.
- Fetches each instruction as four little-endian byte reads over the 8-bit memory port.
- Presents the result with a valid/stall handshake to the decode side.
- Accepts a one-cycle redirect (branch/jump target) from the execute stage.

---
 rtl/if_fetch_pkg.sv | 28 ++
 rtl/if_fetch_if.sv | 30 +++
 rtl/if_fetch.sv | 102 ++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   if_state_e : fetch sequencer states
//   INST_W     : instruction width
//   put_byte   : replace one little-endian byte lane of a 32-bit word
package if_fetch_pkg;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_DRAIN = 2'd2,
    IF_HOLD  = 2'd3
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned INST_W       = 32;

  function automatic logic [INST_W-1:0] put_byte(input logic [INST_W-1:0] word,
                                                 input logic [1:0]        lane,
                                                 input logic [7:0]        b);
    logic [INST_W-1:0] w;
    w = word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane == 2'(i)) w[8*i +: 8] = b;
    end
    return w;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Bus bundle of the fetch stage: 8-bit memory read port plus the
// valid/stall handshake towards decode.
//   master : fetch side (drives mem_req/mem_addr and if_valid/if_pc/if_inst)
//   slave  : memory + decode side (drives mem_rvalid/mem_rdata and stall_i)
interface if_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  import if_fetch_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;

  logic              stall_i;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;

  modport master (
    output mem_req, mem_addr, if_valid, if_pc, if_inst,
    input  mem_rvalid, mem_rdata, stall_i
  );

  modport slave (
    input  mem_req, mem_addr, if_valid, if_pc, if_inst,
    output mem_rvalid, mem_rdata, stall_i
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the fetch PC, assembles each instruction
// from four little-endian byte reads and presents it to decode with a
// valid/stall handshake. A one-cycle br_en pulse redirects fetch.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   br_en      redirect pulse (priority over everything else)
//   br_target  redirect PC, taken as-is
//   bus        if_fetch_if.master: mem_req/mem_addr/mem_rvalid/mem_rdata,
//              stall_i/if_valid/if_pc/if_inst
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_en,
  input  logic [ADDR_W-1:0] br_target,
  if_fetch_if.master        bus
);

  if_state_e         state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        cnt;
  logic [INST_W-1:0] inst;
  logic              valid_q;
  logic              armed;   // low from reset until the first clock edge after release
  logic              req;

  assign req          = armed && (state == IF_FETCH) && !br_en;
  assign bus.mem_req  = req;
  assign bus.mem_addr = pc + ADDR_W'(cnt);
  assign bus.if_valid = valid_q;
  assign bus.if_pc    = pc;
  assign bus.if_inst  = inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IF_FETCH;
      pc      <= RESET_PC;
      cnt     <= '0;
      inst    <= '0;
      valid_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (br_en) begin
        pc      <= br_target;
        cnt     <= '0;
        valid_q <= 1'b0;
        case (state)
          IF_FETCH: state <= IF_FETCH;
          IF_WAIT:  state <= bus.mem_rvalid ? IF_FETCH : IF_DRAIN;
          // A response arriving together with a redirect in DRAIN is the
          // one being drained, so it also ends the drain.
          IF_DRAIN: state <= bus.mem_rvalid ? IF_FETCH : IF_DRAIN;
          IF_HOLD:  state <= IF_FETCH;
          default:  state <= IF_FETCH;
        endcase
      end else begin
        case (state)
          IF_FETCH: begin
            if (req) state <= IF_WAIT;
          end
          IF_WAIT: begin
            if (bus.mem_rvalid) begin
              inst <= put_byte(inst, cnt, bus.mem_rdata);
              if (cnt == 2'd3) begin
                state   <= IF_HOLD;
                valid_q <= 1'b1;
              end else begin
                cnt   <= cnt + 2'd1;
                state <= IF_FETCH;
              end
            end
          end
          IF_DRAIN: begin
            if (bus.mem_rvalid) begin
              cnt   <= '0;
              state <= IF_FETCH;
            end
          end
          IF_HOLD: begin
            if (!bus.stall_i) begin
              pc      <= pc + ADDR_W'(4);
              cnt     <= '0;
              valid_q <= 1'b0;
              state   <= IF_FETCH;
            end
          end
          default: state <= IF_FETCH;
        endcase
      end
    end
  end

  // A read response is only legal while one is outstanding.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_rvalid && (state == IF_FETCH || state == IF_HOLD)));

endmodule
